// File: rtl/debounce_pkg.sv
// Shared types for the debounce / edge-detect stage.
package debounce_pkg;

    // Two settled levels, each with a "waiting to leave" state.
    typedef enum logic [1:0] {
        ST_LOW,
        WAIT_HIGH,
        ST_HIGH,
        WAIT_LOW
    } db_state_t;

endpackage

// File: rtl/debounce_edge_detect.sv
// Debounce filter with rise/fall pulse generation and a rise-event counter.
// The input must already be synchronized to clk_i; the parent owns the
// synchronizer so that CDC handling stays in one place.
module debounce_edge_detect
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int COUNT_W       = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_sync_i,
    input  logic               clear_count_i,
    output logic               level_o,
    output logic               rise_o,
    output logic               fall_o,
    output logic [COUNT_W-1:0] rise_count_o
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    // Value of cnt on the edge that completes the stability window.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // A window of one sample would make the filter transparent.
    if (STABLE_CYCLES < 2) begin : g_bad_stable_cycles
        $error("debounce_edge_detect: STABLE_CYCLES must be >= 2");
    end

    db_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             accept_rise;

    // A rise is accepted on the edge that completes the high window.
    assign accept_rise = (state == WAIT_HIGH) && in_sync_i && (cnt == CNT_LAST);

    // Debounce FSM with registered level and one-cycle edge pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_LOW;
            cnt     <= '0;
            level_o <= 1'b0;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle; the accepting branch
            // below overrides this, so each pulse lasts exactly one cycle.
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            case (state)
                ST_LOW: begin
                    if (in_sync_i) begin
                        state <= WAIT_HIGH;
                        cnt   <= CNT_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (!in_sync_i) begin
                        // Glitch: fall back without touching the outputs.
                        state <= ST_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= ST_HIGH;
                        level_o <= 1'b1;
                        rise_o  <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (!in_sync_i) begin
                        state <= WAIT_LOW;
                        cnt   <= CNT_W'(1);
                    end
                end
                WAIT_LOW: begin
                    if (in_sync_i) begin
                        state <= ST_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= ST_LOW;
                        level_o <= 1'b0;
                        fall_o  <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Wrapping count of accepted rises; a clear overrides a same-cycle rise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rise_count_o <= '0;
        end else if (clear_count_i) begin
            rise_count_o <= '0;
        end else if (accept_rise) begin
            rise_count_o <= rise_count_o + COUNT_W'(1);
        end
    end

endmodule

// File: doc/debounce_edge_detect.md
# debounce_edge_detect

Filter and edge-detect stage that sits directly downstream of `synchronizer`. It consumes the already-synchronized `out_sync_o` and accepts a level change only after the input has held stable for `STABLE_CYCLES` consecutive clock edges. It then produces a clean debounced level, single-cycle rise and fall pulses, and a wrapping count of accepted rising edges. It is used on pushbutton and switch inputs before any control logic.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required to accept a level change. Legal range is ≥2; elaboration fails otherwise.
- `COUNT_W`, default 8: width of the rise-event counter.

- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `in_sync_i`  in  1  synchronized input, driven from `synchronizer.out_sync_o`.
- `clear_count_i`  in  1  synchronous clear of `rise_count_o`.
- `level_o`  out  1  debounced level, registered.
- `rise_o`  out  1  one-cycle pulse on an accepted 0→1 change, registered.
- `fall_o`  out  1  one-cycle pulse on an accepted 1→0 change, registered.
- `rise_count_o`  out  `COUNT_W`  number of accepted rises, wrapping.

## Operation
- The FSM has 4 states: `ST_LOW`, `WAIT_HIGH`, `ST_HIGH`, `WAIT_LOW`.
- Stability counter `cnt` is `$clog2(STABLE_CYCLES)` bits wide.
- `ST_LOW`:
  - `in_sync_i`=1 → `WAIT_HIGH`, `cnt`←1.
  - `in_sync_i`=0 → stay.
- `WAIT_HIGH`:
  - `in_sync_i`=0 → `ST_LOW`, `cnt`←0. This is a glitch reject; no output change.
  - `in_sync_i`=1 and `cnt`==`STABLE_CYCLES`-1 → `ST_HIGH`, `level_o`←1, `rise_o`←1, `cnt`←0.
  - `in_sync_i`=1 otherwise → `cnt`←`cnt`+1.
- `ST_HIGH` and `WAIT_LOW` mirror the above with polarity inverted. The accepted change drives `level_o`←0 and `fall_o`←1.
- `rise_o` and `fall_o` are high for exactly one cycle and are never high together.
- `rise_count_o` increments by 1 in the cycle `rise_o` is set. It wraps from 2^`COUNT_W`-1 to 0 with no saturation.
- `clear_count_i` forces `rise_count_o`←0. If a clear and an accepted rise occur in the same cycle, the clear wins: the count becomes 0, but `rise_o` still pulses.
- An input that toggles every cycle never leaves `ST_LOW`/`WAIT_HIGH`, or `ST_HIGH`/`WAIT_LOW`.

## Timing
- Reset state: FSM=`ST_LOW`, `cnt`=0, `level_o`=0, `rise_o`=0, `fall_o`=0, `rise_count_o`=0. All take effect immediately on `rst_i` assertion, independent of the clock.
- Reset asserted mid-wait abandons the pending change. After release the block behaves as from power-up: the input must again hold for `STABLE_CYCLES` edges.
- Latency: `in_sync_i` sampled at the same value on edges e0…e(N-1), with N=`STABLE_CYCLES` → `level_o` and the pulse are visible after edge e(N-1).
- A pulse of width ≤ N-1 cycles is fully rejected.
- The pulse drops after the following edge.
- End-to-end latency from a raw async pin, including the 2-flop `synchronizer`, is 2+N edges.
- No combinational path exists from any input to any output.

## Structure
- Package `debounce_pkg` contains:
  - `typedef enum logic [1:0] {ST_LOW, WAIT_HIGH, ST_HIGH, WAIT_LOW} db_state_t`.
  - Localparam helper `CNT_W = $clog2(STABLE_CYCLES)`, computed in the module from the parameter; the package holds only the type.
- Single module with no sub-module.
- The `synchronizer` is instantiated by the parent, not inside this block. This keeps CDC handling in one place.

## Test plan
All scenarios use `STABLE_CYCLES`=4 and a 10 ns clock.
- Reset: `rst_i` high 3 cycles with `in_sync_i` toggling → all outputs 0 throughout; state remains `ST_LOW` after release.
- Clean press: `in_sync_i` 0→1 held 10 cycles → `level_o` rises after the 4th sampling edge; `rise_o` high exactly 1 cycle; `rise_count_o`=1.
- Glitch reject: high for 3 cycles, low for 1, high for 3, then low → `level_o` stays 0, no pulses, `rise_count_o` unchanged.
- Release: from `level_o`=1, drop to 0 and hold 6 cycles → `fall_o` pulses once after the 4th low edge; `level_o`=0; count unchanged.
- Wrap and clear: 256 accepted rises → `rise_count_o` returns to 0. Then 2 more rises → 2. Then `clear_count_i` asserted in the same cycle as a rise → count 0, `rise_o`=1.
- Async reset mid-wait: assert `rst_i` between clock edges during `WAIT_HIGH`, `cnt`=2 → outputs 0 immediately. After release, a 3-cycle high gives no rise; a 4-cycle high gives one rise.
